// File: rtl/crc_unfold2_seq.sv
// crc_unfold2_seq
// ---------------------------------------------------------------------------
// Frame sequencer for an external 2-bit-per-clock CRC LFSR datapath
// (generator x^5+x^2+1).  One message word is accepted per frame.  The block
// then clears the datapath and streams the augmented message, two bits per
// clock: the message MSB-first, followed by CRC_W zeros.  It captures the
// datapath remainder and offers it to a consumer.
//
// Handshakes (both sides): a transfer happens on a rising clk edge where
// valid and ready are both high.  A valid source holds its data stable until
// that edge, and it never drops valid before the transfer.  in_ready is high
// only in IDLE, so a word offered while busy simply waits.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   in_valid   message word present
//   in_ready   block can accept a message (IDLE only)
//   in_data    message word, MSB transmitted first
//   crc_clr    one-cycle synchronous clear for the datapath
//   crc_en     datapath advance enable (consumes crc_din this edge)
//   crc_din    bit pair, crc_din[1] is the earlier bit
//   crc_rem    datapath remainder register
//   out_valid  rem_out valid
//   out_ready  consumer takes rem_out
//   rem_out    captured remainder
//   busy       high in every state except IDLE
//   frame_cnt  completed (handed-off) frames, wraps 255->0
//   dbg_state  current FSM state encoding
// ---------------------------------------------------------------------------
module crc_unfold2_seq #(
  parameter int MSG_W = 6,
  parameter int CRC_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [MSG_W-1:0] in_data,
  output logic             crc_clr,
  output logic             crc_en,
  output logic [1:0]       crc_din,
  input  logic [CRC_W-1:0] crc_rem,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CRC_W-1:0] rem_out,
  output logic             busy,
  output logic [7:0]       frame_cnt,
  output logic [2:0]       dbg_state
);

  // Derived sizes; the stream is padded to an even length so it splits
  // into whole bit pairs.
  localparam int N     = MSG_W + CRC_W;
  localparam int NP    = N + (N % 2);
  localparam int BEATS = NP / 2;
  localparam int CW    = $clog2(BEATS + 1);
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_SHIFT  = 3'd2,
    S_SETTLE = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [NP-1:0]     r_shift;
  logic [CW-1:0]     r_beat;
  logic [CRC_W-1:0]  r_rem;
  logic [7:0]        r_frame_cnt;
  logic [NP-1:0]     w_load;
  logic              w_accept;

  assign w_accept = in_valid && (r_state == S_IDLE);

  // Augmented word sits in the low N bits; a pad bit (if any) lands on top
  // as a leading zero, which a cleared datapath ignores.
  always_comb begin
    w_load         = '0;
    w_load[N-1:0]  = {in_data, {CRC_W{1'b0}}};
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_next = S_CLEAR;
      S_CLEAR:  w_next = S_SHIFT;
      S_SHIFT:  if (r_beat == LAST_BEAT) w_next = S_SETTLE;
      S_SETTLE: w_next = S_DONE;
      S_DONE:   if (out_ready) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Decoded outputs
  always_comb begin
    in_ready  = 1'b0;
    crc_clr   = 1'b0;
    crc_en    = 1'b0;
    crc_din   = 2'b00;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
      end
      S_CLEAR: crc_clr = 1'b1;
      S_SHIFT: begin
        crc_en  = 1'b1;
        crc_din = r_shift[NP-1:NP-2];
      end
      S_DONE:  out_valid = 1'b1;
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_shift     <= '0;
      r_beat      <= '0;
      r_rem       <= '0;
      r_frame_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_shift <= w_load;
          r_beat  <= '0;
        end
        S_SHIFT: begin
          r_shift <= {r_shift[NP-3:0], 2'b00};
          r_beat  <= r_beat + 1'b1;
        end
        // The datapath register has absorbed the final beat by now.
        S_SETTLE: r_rem <= crc_rem;
        S_DONE: if (out_ready) r_frame_cnt <= r_frame_cnt + 8'd1;
        default: ;
      endcase
    end
  end

  assign rem_out   = r_rem;
  assign frame_cnt = r_frame_cnt;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_crc_unfold2_seq.sv
// Testbench for crc_unfold2_seq.  Contains a reference x^5+x^2+1 two-bit
// datapath driven by the sequencer, and a scoreboard that predicts each
// remainder by polynomial long division when a word is accepted.
module tb_crc_unfold2_seq;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- DUT signals ----------------
  logic       in_valid, in_ready;
  logic [5:0] in_data;
  logic       crc_clr, crc_en;
  logic [1:0] crc_din;
  logic [4:0] crc_rem;
  logic       out_valid, out_ready;
  logic [4:0] rem_out;
  logic       busy;
  logic [7:0] frame_cnt;
  logic [2:0] dbg_state;

  crc_unfold2_seq dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .crc_clr   (crc_clr),
    .crc_en    (crc_en),
    .crc_din   (crc_din),
    .crc_rem   (crc_rem),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .rem_out   (rem_out),
    .busy      (busy),
    .frame_cnt (frame_cnt),
    .dbg_state (dbg_state)
  );

  // ---------------- reference datapath ----------------
  function automatic logic [4:0] lfsr1(input logic [4:0] r, input logic b);
    return {r[3:0], b} ^ (r[4] ? 5'b00101 : 5'b00000);
  endfunction

  logic [4:0] dp_r = 5'd0;
  always @(posedge clk) begin
    if (crc_clr)     dp_r <= 5'd0;
    else if (crc_en) dp_r <= lfsr1(lfsr1(dp_r, crc_din[1]), crc_din[0]);
  end
  assign crc_rem = dp_r;

  // Remainder of m(x)*x^5 mod (x^5+x^2+1) by long division.
  function automatic logic [4:0] ref_crc(input logic [5:0] m);
    logic [10:0] v;
    logic [10:0] g;
    v = {m, 5'b00000};
    for (int i = 10; i >= 5; i--) begin
      g = 11'b00000100101 << (i - 5);
      if (v[i]) v = v ^ g;
    end
    return v[4:0];
  endfunction

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- scoreboard / monitor ----------------
  logic [4:0] exp_q[$];
  logic [1:0] din_log[$];
  int         clr_cnt  = 0;
  int         acc_cyc  = 0;
  int         lat      = -1;
  logic       prev_ov  = 1'b0;
  logic [4:0] last_rem = 5'h1f;
  logic       chk_busy = 1'b0;

  always @(negedge clk) begin
    if (reset) begin
      if (crc_clr) clr_cnt++;
      if (crc_en)  din_log.push_back(crc_din);
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_crc(in_data));
        acc_cyc = cyc;
      end
      if (out_valid && !prev_ov) lat = cyc - (acc_cyc + 1);
      prev_ov = out_valid;
      if (out_valid && out_ready) begin
        if (exp_q.size() > 0) begin
          chk("rem_out", rem_out, exp_q.pop_front());
          last_rem = rem_out;
        end else begin
          chk("spurious_out", exp_q.size(), 1);
        end
      end
      if (chk_busy) chk("busy_vs_idle", busy, !in_ready);
    end else begin
      prev_ov = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic accept_wait();
    int n = 0;
    while (!in_ready && n < 30) begin
      step();
      n++;
    end
    chk("accept_timeout", in_ready, 1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [5:0] d);
    in_valid = 1'b1;
    in_data  = d;
    accept_wait();
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(exp_q.size() == 0 && in_ready) && n < 40) begin
      step();
      n++;
    end
    chk("idle_timeout", (exp_q.size() == 0 && in_ready), 1);
  endtask

  task automatic wait_out_valid();
    int n = 0;
    while (!out_valid && n < 30) begin
      step();
      n++;
    end
    chk("out_valid_timeout", out_valid, 1);
  endtask

  // ---------------- directed sequence ----------------
  logic [1:0] exp_din [6];
  logic [4:0] rem_hold;
  logic [7:0] fc0;

  initial begin
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 6'd0;
    out_ready = 1'b0;
    exp_din   = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b00, 2'b00};

    // Reset state
    repeat (3) step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_crc_clr", crc_clr, 0);
    chk("rst_crc_en", crc_en, 0);
    chk("rst_crc_din", crc_din, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_rem_out", rem_out, 0);
    chk("rst_state", dbg_state, 0);
    reset = 1'b1;
    step();
    chk("rst_in_ready", in_ready, 1);

    // Frame 101011, consumer always ready
    out_ready = 1'b1;
    din_log.delete();
    clr_cnt = 0;
    send_frame(6'b101011);
    wait_idle();
    chk("f1_rem", last_rem, 5'b10011);
    chk("f1_clr_cycles", clr_cnt, 1);
    chk("f1_beats", din_log.size(), 6);
    for (int i = 0; i < 6; i++)
      chk("f1_din", (din_log.size() > i) ? din_log[i] : 2'bxx, exp_din[i]);
    chk("f1_latency", lat, 8);
    chk("f1_frame_cnt", frame_cnt, 1);

    // All ones
    send_frame(6'b111111);
    wait_idle();
    chk("ones_rem", last_rem, 5'b11101);

    // All zeros: every bit pair must be 00
    din_log.delete();
    send_frame(6'b000000);
    wait_idle();
    chk("zero_rem", last_rem, 5'b00000);
    chk("zero_beats", din_log.size(), 6);
    for (int i = 0; i < 6; i++)
      chk("zero_din", (din_log.size() > i) ? din_log[i] : 2'bxx, 2'b00);

    // Back-pressure: consumer stalls, new word offered and ignored
    out_ready = 1'b0;
    send_frame(6'b110010);
    wait_out_valid();
    rem_hold = rem_out;
    fc0      = frame_cnt;
    in_valid = 1'b1;
    in_data  = 6'b010101;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_rem", rem_out, rem_hold);
      chk("hold_valid", out_valid, 1);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_frame_cnt", frame_cnt, fc0);
    end
    out_ready = 1'b1;
    accept_wait();
    chk("release_one_handoff", frame_cnt, fc0 + 8'd1);
    wait_idle();
    chk("release_next_frame", frame_cnt, fc0 + 8'd2);

    // Reset during the third SHIFT beat
    send_frame(6'b011101);
    repeat (3) step();
    chk("mid_state_shift", dbg_state, 2);
    chk("mid_crc_en", crc_en, 1);
    #2 reset = 1'b0;
    #1;
    exp_q.delete();
    chk("mid_rst_crc_en", crc_en, 0);
    chk("mid_rst_crc_din", crc_din, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_frame_cnt", frame_cnt, 0);
    chk("mid_rst_rem_out", rem_out, 0);
    step();
    reset = 1'b1;
    step();
    chk("post_rst_in_ready", in_ready, 1);
    send_frame(6'b101011);
    wait_idle();
    chk("post_rst_rem", last_rem, 5'b10011);
    chk("post_rst_frame_cnt", frame_cnt, 1);

    // 256 frames: counter wraps, busy tracks non-IDLE
    reset = 1'b0;
    step();
    reset = 1'b1;
    step();
    chk_busy = 1'b1;
    for (int i = 0; i < 256; i++) begin
      send_frame(6'($urandom_range(0, 63)));
      wait_idle();
      if (i == 254) chk("wrap_cnt_255", frame_cnt, 255);
    end
    chk_busy = 1'b0;
    chk("wrap_cnt_0", frame_cnt, 0);
    chk("wrap_queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
